// File: rtl/nx_stat_counter_array.sv
// nx_stat_counter_array
//
// Bank of N_ENTRIES event counters with a coherent snapshot shadow (mem_a).
// Counters can be incremented, cleared one at a time, or cleared in a
// sequenced sweep. A snapshot copies every live counter into mem_a in one
// cycle, so all values read downstream belong to one capture instant.
//
// Optional feature macro: NX_STAT_COUNTER_SATURATE_EN
//   defined   -> counters saturate at all-ones, ovf set on saturation
//   undefined -> counters wrap modulo 2^N_DATA_BITS, ovf set on carry-out
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous active-high reset
//   inc_vld    increment strobe
//   inc_idx    counter index for the increment
//   inc_amt    increment amount (zero-extended)
//   clr_vld    single-entry clear strobe
//   clr_idx    counter index for the clear
//   clr_all    starts the clear-all sweep (ignored while busy)
//   snap_req   snapshot request
//   busy       high while the sweep runs
//   snap_done  one-cycle pulse when mem_a has been updated
//   ovf        sticky overflow / saturation flag
//   mem_a      snapshot shadow array
module nx_stat_counter_array #(
  parameter int N_ENTRIES   = 32,
  parameter int N_DATA_BITS = 64,
  parameter int N_IDX_BITS  = 5,
  parameter int N_INC_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc_vld,
  input  logic [N_IDX_BITS-1:0]  inc_idx,
  input  logic [N_INC_BITS-1:0]  inc_amt,
  input  logic                   clr_vld,
  input  logic [N_IDX_BITS-1:0]  clr_idx,
  input  logic                   clr_all,
  input  logic                   snap_req,
  output logic                   busy,
  output logic                   snap_done,
  output logic                   ovf,
  output logic [N_DATA_BITS-1:0] mem_a [0:N_ENTRIES-1]
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam logic [N_IDX_BITS-1:0] LAST_IDX = N_IDX_BITS'(N_ENTRIES - 1);

  state_t                 state;
  state_t                 state_next;
  logic [N_IDX_BITS-1:0]  sp;
  logic [N_IDX_BITS-1:0]  sp_next;
  logic                   snap_pend;
  logic                   snap_pend_next;
  logic                   snap_take;
  logic                   sweep_start;
  logic                   ovf_event;
  logic [N_DATA_BITS-1:0] live      [0:N_ENTRIES-1];
  logic [N_DATA_BITS-1:0] live_next [0:N_ENTRIES-1];
  logic [N_DATA_BITS-1:0] base;
  logic [N_DATA_BITS:0]   sum;

  // Sweep sequencer and snapshot arbitration. A snapshot requested during
  // the sweep is parked in snap_pend and taken in the first IDLE cycle,
  // where it merges with any fresh request into a single capture.
  always_comb begin
    state_next     = state;
    sp_next        = sp;
    busy           = 1'b0;
    sweep_start    = 1'b0;
    snap_take      = 1'b0;
    snap_pend_next = snap_pend;

    if (state == IDLE) begin
      snap_take = snap_req | snap_pend;
      if (snap_take) begin
        snap_pend_next = 1'b0;
      end
      if (clr_all) begin
        sweep_start = 1'b1;
        state_next  = SWEEP;
        sp_next     = '0;
      end
    end else begin
      busy = 1'b1;
      if (snap_req) begin
        snap_pend_next = 1'b1;
      end
      if (sp == LAST_IDX) begin
        state_next = IDLE;
        sp_next    = '0;
      end else begin
        sp_next = sp + 1'b1;
      end
    end
  end

  // Per-entry next value: clears (single or sweep) act first, then the
  // increment is added on top, so a colliding clear+increment yields inc_amt.
  // Out-of-range indices never match any entry and therefore do nothing.
  always_comb begin
    ovf_event = 1'b0;
    base      = '0;
    sum       = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      base = live[i];
      if ((clr_vld && (clr_idx == N_IDX_BITS'(i))) ||
          ((state == SWEEP) && (sp == N_IDX_BITS'(i)))) begin
        base = '0;
      end
      sum          = {1'b0, base} + (N_DATA_BITS+1)'(inc_amt);
      live_next[i] = base;
      if (inc_vld && (inc_idx == N_IDX_BITS'(i))) begin
        if (sum[N_DATA_BITS]) begin
          ovf_event = 1'b1;
`ifdef NX_STAT_COUNTER_SATURATE_EN
          live_next[i] = '1;
`else
          live_next[i] = sum[N_DATA_BITS-1:0];
`endif
        end else begin
          live_next[i] = sum[N_DATA_BITS-1:0];
        end
      end
    end
  end

  // State, counters and shadow. The snapshot copies the pre-update live
  // values; ovf is cleared by an accepted clr_all, which wins over an
  // overflow in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sp        <= '0;
      snap_pend <= 1'b0;
      snap_done <= 1'b0;
      ovf       <= 1'b0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        live[i]  <= '0;
        mem_a[i] <= '0;
      end
    end else begin
      state     <= state_next;
      sp        <= sp_next;
      snap_pend <= snap_pend_next;
      snap_done <= snap_take;
      if (sweep_start) begin
        ovf <= 1'b0;
      end else if (ovf_event) begin
        ovf <= 1'b1;
      end
      for (int i = 0; i < N_ENTRIES; i++) begin
        live[i] <= live_next[i];
        if (snap_take) begin
          mem_a[i] <= live[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_nx_stat_counter_array.sv
// Testbench for nx_stat_counter_array.
// Main instance uses 16-bit counters so overflow is reachable with 8-bit
// increments; a second instance (N_ENTRIES=40, N_IDX_BITS=6, 64-bit) covers
// out-of-range indices.
module tb_nx_stat_counter_array;

  localparam int NE = 32;
  localparam int DW = 16;
  localparam int IW = 5;
  localparam int AW = 8;
  localparam longint MAXV = (64'd1 << DW) - 1;
`ifdef NX_STAT_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    bit rst;
    bit iv;
    int ii;
    int ia;
    bit cv;
    int ci;
    bit ca;
    bit sr;
  } stim_t;

  typedef struct {
    stim_t s;
    bit    exp_done;
    bit    exp_busy;
    int    chk_idx;
    int    exp_val;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, inc_vld, clr_vld, clr_all, snap_req;
  logic [IW-1:0] inc_idx, clr_idx;
  logic [AW-1:0] inc_amt;
  logic          busy, snap_done, ovf;
  logic [DW-1:0] mem_a [0:NE-1];

  nx_stat_counter_array #(
    .N_ENTRIES(NE), .N_DATA_BITS(DW), .N_IDX_BITS(IW), .N_INC_BITS(AW)
  ) dut (
    .clk(clk), .reset(reset), .inc_vld(inc_vld), .inc_idx(inc_idx),
    .inc_amt(inc_amt), .clr_vld(clr_vld), .clr_idx(clr_idx),
    .clr_all(clr_all), .snap_req(snap_req), .busy(busy),
    .snap_done(snap_done), .ovf(ovf), .mem_a(mem_a)
  );

  logic        reset_b = 1'b1;
  logic        inc_vld_b = 1'b0, clr_vld_b = 1'b0, clr_all_b = 1'b0, snap_req_b = 1'b0;
  logic [5:0]  inc_idx_b = '0, clr_idx_b = '0;
  logic [7:0]  inc_amt_b = '0;
  logic        busy_b, snap_done_b, ovf_b;
  logic [63:0] mem_b [0:39];

  nx_stat_counter_array #(
    .N_ENTRIES(40), .N_DATA_BITS(64), .N_IDX_BITS(6), .N_INC_BITS(8)
  ) dut40 (
    .clk(clk), .reset(reset_b), .inc_vld(inc_vld_b), .inc_idx(inc_idx_b),
    .inc_amt(inc_amt_b), .clr_vld(clr_vld_b), .clr_idx(clr_idx_b),
    .clr_all(clr_all_b), .snap_req(snap_req_b), .busy(busy_b),
    .snap_done(snap_done_b), .ovf(ovf_b), .mem_a(mem_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the counters as plain numbers, the sweep as a position
  logic [DW-1:0] m_live [0:NE-1];
  logic [DW-1:0] m_mem  [0:NE-1];
  bit            m_ovf, m_done, m_pend, m_sweeping;
  int            m_pos;

  function automatic stim_t st(bit rst, bit iv, int ii, int ia,
                               bit cv, int ci, bit ca, bit sr);
    stim_t s;
    s.rst = rst; s.iv = iv; s.ii = ii; s.ia = ia;
    s.cv = cv; s.ci = ci; s.ca = ca; s.sr = sr;
    return s;
  endfunction

  function automatic vec_t vc(stim_t s, bit d, bit b, int idx, int val);
    vec_t v;
    v.s = s; v.exp_done = d; v.exp_busy = b; v.chk_idx = idx; v.exp_val = val;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic modelStep(input stim_t s);
    bit     take, ev;
    longint total;
    if (s.rst) begin
      for (int i = 0; i < NE; i++) begin
        m_live[i] = '0;
        m_mem[i]  = '0;
      end
      m_ovf = 0; m_done = 0; m_pend = 0; m_sweeping = 0; m_pos = 0;
      return;
    end
    ev   = 0;
    take = !m_sweeping && (s.sr || m_pend);
    if (take) begin
      for (int i = 0; i < NE; i++) m_mem[i] = m_live[i];
    end
    m_done = take;
    if (m_sweeping && s.sr) m_pend = 1;
    else if (take) m_pend = 0;
    if (s.cv && s.ci < NE) m_live[s.ci] = '0;
    if (m_sweeping) m_live[m_pos] = '0;
    if (s.iv && s.ii < NE) begin
      total = longint'(m_live[s.ii]) + longint'(s.ia);
      if (total > MAXV) begin
        ev = 1;
        total = SAT ? MAXV : total - (MAXV + 1);
      end
      m_live[s.ii] = DW'(total);
    end
    if (!m_sweeping && s.ca) m_ovf = 0;
    else if (ev) m_ovf = 1;
    if (m_sweeping) begin
      m_pos++;
      if (m_pos == NE) begin
        m_sweeping = 0;
        m_pos = 0;
      end
    end else if (s.ca) begin
      m_sweeping = 1;
      m_pos = 0;
    end
  endtask

  task automatic checkOutput();
    int bad;
    bad = 0;
    checkValue("busy", busy, m_sweeping);
    checkValue("snap_done", snap_done, m_done);
    checkValue("ovf", ovf, m_ovf);
    for (int i = 0; i < NE; i++) begin
      if (mem_a[i] !== m_mem[i]) begin
        bad = i;
        break;
      end
    end
    checkValue($sformatf("mem_a[%0d]", bad), mem_a[bad], m_mem[bad]);
  endtask

  task automatic applyStimulus(input stim_t s);
    reset    = s.rst;
    inc_vld  = s.iv;
    inc_idx  = IW'(s.ii);
    inc_amt  = AW'(s.ia);
    clr_vld  = s.cv;
    clr_idx  = IW'(s.ci);
    clr_all  = s.ca;
    snap_req = s.sr;
    @(posedge clk);
    modelStep(s);
    #1;
    checkOutput();
  endtask

  function automatic stim_t idle();
    return st(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t incr(int idx, int amt);
    return st(0, 1, idx, amt, 0, 0, 0, 0);
  endfunction

  function automatic stim_t snap();
    return st(0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic step40();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[13];
  stim_t s;

  initial begin
    tbl[0]  = vc(incr(2, 3), 0, 0, 2, 0);
    tbl[1]  = vc(incr(2, 5), 0, 0, 2, 0);
    tbl[2]  = vc(incr(2, 7), 0, 0, 2, 0);
    tbl[3]  = vc(snap(), 1, 0, 2, 15);
    tbl[4]  = vc(idle(), 0, 0, 2, 15);
    tbl[5]  = vc(incr(4, 9), 0, 0, 4, 0);
    tbl[6]  = vc(st(0, 1, 4, 1, 0, 0, 0, 1), 1, 0, 4, 9);
    tbl[7]  = vc(snap(), 1, 0, 4, 10);
    tbl[8]  = vc(idle(), 0, 0, 4, 10);
    tbl[9]  = vc(incr(7, 5), 0, 0, 7, 0);
    tbl[10] = vc(st(0, 1, 7, 6, 1, 7, 0, 0), 0, 0, 7, 0);
    tbl[11] = vc(snap(), 1, 0, 7, 6);
    tbl[12] = vc(idle(), 0, 0, 2, 15);

    // Reset
    applyStimulus(st(1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(st(1, 0, 0, 0, 0, 0, 0, 0));
    checkValue("reset_mem0", mem_a[0], 0);

    // Directed vectors: increment, snapshot ordering, clear collision
    foreach (tbl[k]) begin
      applyStimulus(tbl[k].s);
      checkValue($sformatf("tbl%0d_done", k), snap_done, tbl[k].exp_done);
      checkValue($sformatf("tbl%0d_busy", k), busy, tbl[k].exp_busy);
      checkValue($sformatf("tbl%0d_mem", k), mem_a[tbl[k].chk_idx], tbl[k].exp_val);
    end

    // Load every entry, then drive idx 1 to 2^DW-2 and overflow it
    for (int i = 0; i < NE; i++) applyStimulus(incr(i, i + 1));
    for (int i = 0; i < 256; i++) applyStimulus(incr(1, 255));
    applyStimulus(incr(1, 252));
    applyStimulus(snap());
    checkValue("preload_idx1", mem_a[1], MAXV - 1);
    checkValue("preload_ovf", ovf, 0);
    applyStimulus(incr(1, 4));
    checkValue("ovf_set", ovf, 1);
    applyStimulus(snap());
    checkValue("ovf_value", mem_a[1], SAT ? MAXV : 64'd2);

    // Clear-all with a pending snapshot and an increment behind the pointer
    applyStimulus(st(0, 0, 0, 0, 0, 0, 1, 0));
    checkValue("sweep_busy_t1", busy, 1);
    checkValue("sweep_ovf_t1", ovf, 0);
    for (int c = 1; c <= 35; c++) begin
      s = st(0, (c == 10), 0, 2, 0, 0, 0, (c == 5));
      applyStimulus(s);
      checkValue($sformatf("sweep_busy_c%0d", c), busy, (c <= 31));
      checkValue($sformatf("sweep_done_c%0d", c), snap_done, (c == 33));
    end
    checkValue("sweep_mem0", mem_a[0], 2);
    checkValue("sweep_mem1", mem_a[1], 0);
    checkValue("sweep_mem31", mem_a[31], 0);

    // Reset in the middle of a sweep with a snapshot pending
    applyStimulus(st(0, 0, 0, 0, 0, 0, 1, 0));
    for (int c = 1; c <= 10; c++) applyStimulus(st(0, 1, c, 9, 0, 0, 0, (c == 3)));
    applyStimulus(st(1, 0, 0, 0, 0, 0, 0, 0));
    checkValue("midreset_busy", busy, 0);
    for (int c = 0; c < 40; c++) begin
      applyStimulus(idle());
      checkValue($sformatf("midreset_done_c%0d", c), snap_done, 0);
    end
    checkValue("midreset_mem0", mem_a[0], 0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      s.rst = ($urandom_range(0, 499) == 0);
      s.iv  = ($urandom_range(0, 3) != 0);
      s.ii  = $urandom_range(0, NE - 1);
      s.ia  = $urandom_range(0, 255);
      s.cv  = ($urandom_range(0, 7) == 0);
      s.ci  = $urandom_range(0, NE - 1);
      s.ca  = ($urandom_range(0, 99) == 0);
      s.sr  = ($urandom_range(0, 9) == 0);
      applyStimulus(s);
    end

    // Out-of-range indices on the 40-entry instance
    reset_b = 1'b1;
    step40();
    reset_b   = 1'b0;
    inc_vld_b = 1'b1; inc_idx_b = 6'd40; inc_amt_b = 8'd5;
    clr_vld_b = 1'b1; clr_idx_b = 6'd40;
    step40();
    inc_idx_b = 6'd63;
    step40();
    inc_vld_b = 1'b0; clr_vld_b = 1'b0; snap_req_b = 1'b1;
    step40();
    snap_req_b = 1'b0;
    checkValue("oor_done", snap_done_b, 1);
    checkValue("oor_ovf", ovf_b, 0);
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < 40; i++) if (mem_b[i] !== 64'd0) nz++;
      checkValue("oor_nonzero_entries", 64'(nz), 0);
    end
    inc_vld_b = 1'b1; inc_idx_b = 6'd39; inc_amt_b = 8'd9;
    step40();
    inc_vld_b = 1'b0; snap_req_b = 1'b1;
    step40();
    snap_req_b = 1'b0;
    checkValue("idx39_value", mem_b[39], 9);
    checkValue("idx8_value", mem_b[8], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nx_stat_counter_array.md
# nx_stat_counter_array

Bank of N_ENTRIES event counters with a coherent snapshot shadow. The shadow is driven out as `mem_a` and feeds the read-only indirect register array directly downstream. Software reads those counters through the indirect CMND/STAT interface. The block provides single-entry clear, a sequenced clear-all sweep, and an atomic snapshot, so every value software reads belongs to one consistent capture instant.

## Interface
- `N_ENTRIES`, 32: number of counters; sets the length of `mem_a`.
- `N_DATA_BITS`, 64: counter width.
- `N_IDX_BITS`, 5: index width; must satisfy 2^N_IDX_BITS >= N_ENTRIES.
- `N_INC_BITS`, 8: width of the increment amount.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inc_vld`  in  1  increment strobe, one event per cycle.
- `inc_idx`  in  N_IDX_BITS  target counter of the increment.
- `inc_amt`  in  N_INC_BITS  amount added, zero-extended to N_DATA_BITS.
- `clr_vld`  in  1  single-entry clear strobe.
- `clr_idx`  in  N_IDX_BITS  counter to clear.
- `clr_all`  in  1  starts the clear-all sweep.
- `snap_req`  in  1  request to copy all live counters into `mem_a`.
- `busy`  out  1  high while the sweep is running.
- `snap_done`  out  1  one-cycle pulse when `mem_a` has been updated.
- `ovf`  out  1  sticky: set when any counter overflows or saturates.
- `mem_a`  out  [N_DATA_BITS-1:0] x [0:N_ENTRIES-1]  snapshot shadow array.

## Operation
- Live counters are internal flops and are not visible at the ports; `mem_a` changes only on a snapshot or on reset.
- **Increment:** `live[inc_idx] += inc_amt`.
  - An index >= N_ENTRIES is dropped and has no side effects.
  - Overflow sets `ovf`.
- **Single clear:** `live[clr_idx] = 0`.
  - An out-of-range index is ignored.
  - Allowed while `busy`.
- **Same cycle, same index, increment and clear:** the clear applies first, so the result is `inc_amt`. This holds for both single clears and the sweep's current entry.
- **FSM IDLE / SWEEP, with pointer `sp`:**
  - IDLE -> SWEEP when `clr_all` is high in IDLE; `sp` = 0.
  - SWEEP clears `live[sp]` each cycle and increments `sp`.
  - SWEEP -> IDLE after clearing entry N_ENTRIES-1.
  - `clr_all` while in SWEEP is ignored.
- Increments during SWEEP apply normally:
  - Entries with index < `sp` accumulate from zero.
  - Entries with index > `sp` are cleared later.
- **Snapshot when not busy:** copies `live` into `mem_a`. Values are taken before that cycle's increment or clear.
- **Snapshot while busy:** sets `snap_pend`. The pending snapshot is taken in the first IDLE cycle after the sweep and captures the fully cleared state plus any post-sweep accumulation.
  - Repeated requests while pending merge into one.
  - `snap_req` in the first IDLE cycle merges with the pending one and produces a single `snap_done`.
- **`ovf`** is cleared only by `reset` or by `clr_all`.

## Timing
- **Reset values:**
  - All `live` entries and all `mem_a` entries are 0.
  - `busy` = 0, `snap_done` = 0, `ovf` = 0, `snap_pend` = 0, FSM in IDLE, `sp` = 0.
- **Reset mid-sweep:** aborts the sweep and drops any pending snapshot.
- **Increment:** applied at cycle t is visible in `live` at t+1.
- **Snapshot:**
  - `snap_req` at t while IDLE gives `mem_a` valid at t+1 and `snap_done` high at t+1 for exactly one cycle.
  - Back-to-back snapshot requests give back-to-back `snap_done` pulses.
- **Sweep:**
  - `clr_all` at t gives `busy` high from t+1 through t+N_ENTRIES.
  - Entry k reads 0 from t+2+k.
  - `ovf` is cleared at t+1.
  - A pending snapshot is taken at t+N_ENTRIES+1, with `snap_done` at t+N_ENTRIES+2.
- **Arithmetic:** wrap modulo 2^N_DATA_BITS unless saturation is compiled in (see Configuration).

## Configuration
- Macro: `NX_STAT_COUNTER_SATURATE_EN`.
- **Defined:**
  - A counter whose sum would exceed 2^N_DATA_BITS-1 holds at all-ones.
  - `ovf` is set on that saturating event.
- **Undefined:**
  - Counters wrap modulo 2^N_DATA_BITS.
  - `ovf` is set on the carry-out.

## Test plan
- **Reset and increment:** reset, then increments of 3, 5 and 7 to idx 2, then `snap_req`. Expect `mem_a[2]` = 15, all other entries 0, and a single `snap_done` one cycle after the request.
- **Snapshot ordering:** `snap_req` in the same cycle as an increment of 1 to idx 4 (live value 9). Expect `mem_a[4]` = 9. A second snapshot then gives 10.
- **Clear and increment collision:**
  - `clr_vld` and an increment of 6 both to idx 7 in one cycle, followed by a snapshot: expect `mem_a[7]` = 6.
  - Out-of-range idx 40 with N_ENTRIES=40 and N_IDX_BITS=6: no change anywhere.
- **Clear-all with pending snapshot:**
  - Load all 32 entries with nonzero values and set `ovf` via overflow.
  - Issue `clr_all` at t; expect `busy` high t+1..t+32 and `ovf` = 0 at t+1.
  - `snap_req` at t+5 is held pending; `snap_done` at t+34, with all entries 0.
  - Increment idx 0 by 2 at t+10; the later snapshot shows `mem_a[0]` = 2.
- **Overflow:** preload idx 1 to 2^64-2, then increment by 4. Expect `ovf` = 1 and `mem_a[1]`:
  - 2 without `NX_STAT_COUNTER_SATURATE_EN`;
  - 0xFFFF_FFFF_FFFF_FFFF with it.
- **Reset mid-sweep:** assert `reset` at sweep entry 10 while a snapshot is pending. Expect `busy` = 0 next cycle, no `snap_done`, and all `mem_a` entries 0.
